// File: rtl/mux_4to1_reg.sv
// ---------------------------------------------------------------------------
// mux_4to1_reg
//
// Registered 4-to-1 multiplexer. The two select bits s1 (MSB) and s0 (LSB)
// pick one of the four data inputs. The chosen word is captured on the rising
// edge of clk and shown on result for the following cycle. Use it in place of a
// purely combinational mux wherever the steered value has to be registered.
//
// Parameters
//   WIDTH      bit width of d0..d3 and result (must be >= 1)
//   RESET_VAL  value that result takes while rst is sampled high
//
// Ports
//   clk     in   1      single clock, all state changes on the rising edge
//   rst     in   1      synchronous, active-high reset (overrides the mux path)
//   d0      in   WIDTH  data input, selected when {s1,s0} = 2'b00
//   d1      in   WIDTH  data input, selected when {s1,s0} = 2'b01
//   d2      in   WIDTH  data input, selected when {s1,s0} = 2'b10
//   d3      in   WIDTH  data input, selected when {s1,s0} = 2'b11
//   s0      in   1      select LSB
//   s1      in   1      select MSB
//   result  out  WIDTH  registered mux output, one cycle behind its inputs
// ---------------------------------------------------------------------------
module mux_4to1_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] result
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] muxout;

  assign sel = {s1, s0};

  // Combinational select. muxout gets a value before the case statement, so
  // every path assigns it. That default keeps the block free of latches, even
  // when sel carries X or Z and no case arm matches. Output is left undefined
  // in that situation, so falling back to d0 is acceptable.
  always_comb begin
    muxout = d0;
    case (sel)
      2'b00: muxout = d0;
      2'b01: muxout = d1;
      2'b10: muxout = d2;
      2'b11: muxout = d3;
      default: muxout = d0;
    endcase
  end

  // Output register and the only state in the block. Reset is checked first,
  // so it wins over the mux path and drops any value already in flight. There
  // is no enable, so every cycle without reset loads the selected input.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= RESET_VAL;
    end else begin
      result <= muxout;
    end
  end

endmodule

// File: tb/tb_mux_4to1_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_4to1_reg
//
// Directed testbench for mux_4to1_reg. It builds two instances that share
// clock, reset and select. One is the 1-bit default instance. The other is an
// 8-bit instance with a non-zero reset value.
// ---------------------------------------------------------------------------
module tb_mux_4to1_reg;

  localparam logic [7:0] RESET8 = 8'hA5;

  logic       clk;
  logic       rst;
  logic       s0;
  logic       s1;
  logic       a0, a1, a2, a3;
  logic       res1;
  logic [7:0] b0, b1, b2, b3;
  logic [7:0] res8;

  int vectorCount;
  int miscompareCount;

  mux_4to1_reg dut1 (
    .clk   (clk),
    .rst   (rst),
    .d0    (a0),
    .d1    (a1),
    .d2    (a2),
    .d3    (a3),
    .s0    (s0),
    .s1    (s1),
    .result(res1)
  );

  mux_4to1_reg #(
    .WIDTH    (8),
    .RESET_VAL(RESET8)
  ) dut8 (
    .clk   (clk),
    .rst   (rst),
    .d0    (b0),
    .d1    (b1),
    .d2    (b2),
    .d3    (b3),
    .s0    (s0),
    .s1    (s1),
    .result(res8)
  );

  // 100 MHz style free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point. Every check is counted, and each mismatch is
  // reported with the observed and expected values.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives reset, the select and the 1-bit data, then advances one rising
  // edge. Sampling happens 1ns after that edge, well away from it.
  task automatic applyStimulus(input logic r, input logic [1:0] sel,
                               input logic [3:0] dbits);
    rst = r;
    {s1, s0} = sel;
    {a3, a2, a1, a0} = dbits;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] v;
    logic [3:0] dv;
    logic       expBit;
    logic [7:0] pat8 [4];

    vectorCount     = 0;
    miscompareCount = 0;
    pat8[0] = 8'h11;
    pat8[1] = 8'h22;
    pat8[2] = 8'h44;
    pat8[3] = 8'h88;
    b0 = pat8[0];
    b1 = pat8[1];
    b2 = pat8[2];
    b3 = pat8[3];
    rst = 1'b1;
    {s1, s0} = 2'b11;
    {a3, a2, a1, a0} = 4'b1111;
    #2;

    $display("[TB] reset with all data high and sel=11");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 2'b11, 4'b1111);
      checkOutput("reset1", {7'd0, res1}, 8'h00);
      checkOutput("reset8", res8, RESET8);
    end
    applyStimulus(1'b0, 2'b11, 4'b1111);
    checkOutput("release1", {7'd0, res1}, 8'h01);
    checkOutput("release8", res8, 8'h88);

    $display("[TB] exhaustive 1-bit sweep");
    for (int i = 0; i < 64; i++) begin
      v  = 6'(i);
      dv = v[3:0];
      expBit = dv[v[5:4]];
      applyStimulus(1'b0, v[5:4], dv);
      checkOutput("sweep", {7'd0, res1}, {7'd0, expBit});
    end

    $display("[TB] isolation of unselected inputs");
    for (int i = 0; i < 6; i++) begin
      dv = (i % 2 == 0) ? 4'b1101 : 4'b0000;
      applyStimulus(1'b0, 2'b01, dv);
      checkOutput("isolate", {7'd0, res1}, 8'h00);
    end
    applyStimulus(1'b0, 2'b01, 4'b0010);
    checkOutput("isolate_d1", {7'd0, res1}, 8'h01);

    $display("[TB] latency check");
    applyStimulus(1'b0, 2'b00, 4'b1000);
    checkOutput("lat_pre", {7'd0, res1}, 8'h00);
    {s1, s0} = 2'b11;
    #2;
    checkOutput("lat_before_edge", {7'd0, res1}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("lat_after_edge", {7'd0, res1}, 8'h01);

    $display("[TB] sweep with mid-stream reset at vector 30");
    for (int i = 0; i < 64; i++) begin
      v  = 6'(i);
      dv = v[3:0];
      expBit = dv[v[5:4]];
      if (i == 30) begin
        applyStimulus(1'b1, v[5:4], dv);
        checkOutput("midrst1", {7'd0, res1}, 8'h00);
        checkOutput("midrst8", res8, RESET8);
      end else begin
        applyStimulus(1'b0, v[5:4], dv);
        checkOutput("midsweep", {7'd0, res1}, {7'd0, expBit});
      end
    end

    $display("[TB] 8-bit select cycling");
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b0, 2'(i), 4'b0000);
        checkOutput("wide8", res8, pat8[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
